folded_threshold_eval: RTL
==========================

// Module: folded_threshold_eval
// PURPOSE
//   Sequential, parametrised successor to the flat Maj33 gate: evaluates y = (popcount(x) >= T)
//   for an N-bit vector by folding it into W-bit chunks, one chunk per clock, into a popcount
//   accumulator. Supports fixed-majority or run-time threshold mode, optional early decision,
//   and valid/ready handshakes on both sides. Sits between vector producers and decision logic.
// PARAMETERS
//   N          33            input vector width (>=1)
//   W          8             bits folded per cycle (1..N); C = ceil(N/W) chunks
//   EARLY_EXIT 0             1: finish as soon as the result is decided
//   CNT_W      $clog2(N+1)   accumulator / threshold width (derived, do not override)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      vector + mode + threshold valid
//   in_ready   out  1      block can accept a vector
//   in_data    in   N      vector x; bit i = x_i
//   in_mode    in   1      0: majority, T = N/2+1 (floor div); 1: T = in_thresh
//   in_thresh  in   CNT_W  threshold for in_mode=1
//   out_valid  out  1      result valid, held until taken
//   out_ready  in   1      consumer takes result
//   out_y      out  1      1 iff count >= T
//   out_cnt    out  CNT_W  accumulated popcount
//   out_early  out  1      1 iff decided before all C chunks were summed
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, acc=0, chunk idx=0, out_valid=0,
//     out_y=0, out_cnt=0, out_early=0. Reset mid-ACCUM or DONE aborts; result is lost.
//   - FSM IDLE -> ACCUM -> DONE. in_ready = (IDLE) | (DONE & out_ready); never in ACCUM.
//   - Accept on in_valid & in_ready: latch in_data, T (resolved from mode), idx=0, acc=0.
//   - ACCUM: each cycle acc += popcount(chunk idx); chunk idx = in_data[idx*W +: W];
//     the last chunk is zero-padded above bit N-1. idx increments per cycle.
//   - EARLY_EXIT=0: after chunk C-1 is added -> DONE. out_valid rises exactly C cycles
//     after the accepting edge; out_cnt = full popcount; out_early=0.
//   - EARLY_EXIT=1: after adding chunk idx, go DONE if acc >= T (y=1) or
//     acc + bits_remaining < T (y=0); out_cnt = partial acc; out_early=1 if idx < C-1.
//     Latency is 1..C cycles; y identical to the non-early result.
//   - T=0: y=1 always. T>N: y=0 always. Both still take the normal path (no bypass in
//     EARLY_EXIT=0; with EARLY_EXIT=1 they decide after chunk 0).
//   - DONE: out_* stable while out_valid & !out_ready. out_valid & out_ready & in_valid:
//     result retired and new vector accepted on the same edge -> ACCUM next cycle
//     (throughput one vector per C+1 cycles at EARLY_EXIT=0 with no stall... C cycles
//     ACCUM + 1 DONE). out_valid & out_ready & !in_valid -> IDLE, out_valid=0.
//   - acc never overflows: CNT_W holds N. in_data/in_mode/in_thresh ignored when not accepted.
// TESTING (N=33, W=8, C=5 unless noted)
//   1 reset, x=0x1_0000_FFFF (17 ones), mode=0 -> out_valid 5 cycles after accept,
//     y=1, cnt=17; x with 16 ones -> y=0, cnt=16.
//   2 mode=1, T=0 with x=0 -> y=1; T=34 with x=all ones -> y=0, cnt=33.
//   3 out_ready held low 7 cycles -> outputs stable, in_ready=0; then out_ready=1 with
//     in_valid=1 -> same-edge retire+accept, next result after 5 more cycles.
//   4 EARLY_EXIT=1, x=all ones, mode=0 -> done after chunk 2 (24>=17), early=1, cnt=24;
//     x=0 -> y=0 after chunk 2 (0+9<17), early=1.
//   5 rst_n pulsed low mid-ACCUM (idx=2) -> out_valid=0, in_ready=1 immediately, no result.
//   6 random 10k vectors, N=33/W in {1,8,33} and N=8/W=3, both EARLY_EXIT -> y matches
//     (popcount>=T) scoreboard, no lost or duplicated results.

Source files
------------

// File: rtl/folded_threshold_eval.sv
// Threshold evaluator y = (popcount(x) >= T). The N-bit vector is folded into W-bit
// chunks, and one chunk per clock is added into a popcount accumulator.
module folded_threshold_eval #(
  parameter int N          = 33,
  parameter int W          = 8,
  parameter int EARLY_EXIT = 0,
  parameter int CNT_W      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_mode,
  input  logic [CNT_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_early
);

  localparam int C     = (N + W - 1) / W;
  localparam int IDX_W = (C > 1) ? $clog2(C) : 1;
  localparam int PAD_W = C * W;
  localparam logic [CNT_W-1:0] MAJ_T = CNT_W'(N / 2 + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [PAD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             y_q, y_d;
  logic             early_q, early_d;

  logic             accept;
  logic [W-1:0]     chunk;
  logic [CNT_W-1:0] chunk_cnt;
  logic [CNT_W-1:0] remaining;
  int               rem_int;
  logic [CNT_W:0]   acc_sum, acc_bound, thresh_ext;
  logic             last_chunk, hit, miss;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // The last chunk reads the zero padding above bit N-1, so it never adds stray ones.
  assign chunk = data_q[idx_q*W +: W];

  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < W; i++) chunk_cnt = chunk_cnt + CNT_W'(chunk[i]);
  end

  // Bits still unsummed once the current chunk is added; bounds the best-case final count.
  always_comb begin
    rem_int   = N - (int'(idx_q) + 1) * W;
    remaining = (rem_int > 0) ? CNT_W'(rem_int) : '0;
  end

  assign acc_sum    = {1'b0, acc_q + chunk_cnt};
  assign acc_bound  = acc_sum + {1'b0, remaining};
  assign thresh_ext = {1'b0, thresh_q};
  assign last_chunk = (idx_q == IDX_W'(C - 1));
  assign hit        = (acc_sum >= thresh_ext);
  assign miss       = (acc_bound < thresh_ext);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    data_d   = data_q;
    thresh_d = thresh_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    y_d      = y_q;
    early_d  = early_q;

    case (state_q)
      ACCUM: begin
        acc_d = acc_sum[CNT_W-1:0];
        idx_d = idx_q + IDX_W'(1);
        if (last_chunk || ((EARLY_EXIT != 0) && (hit || miss))) begin
          state_d = DONE;
          y_d     = hit;
          early_d = !last_chunk;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept in IDLE, or in DONE on the same edge the result is retired.
    if (accept) begin
      state_d  = ACCUM;
      data_d   = PAD_W'(in_data);
      thresh_d = in_mode ? in_thresh : MAJ_T;
      acc_d    = '0;
      idx_d    = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      early_q <= early_d;
    end
  end

  // NOTE: the vector and threshold holding registers are not reset; they are only read after a load.
  always_ff @(posedge clk) begin
    data_q   <= data_d;
    thresh_q <= thresh_d;
  end

  assign out_valid = (state_q == DONE);
  assign out_y     = y_q;
  assign out_cnt   = acc_q;
  assign out_early = early_q;

endmodule
